// File: rtl/row_unpacker.sv
// Streams one captured wide row out as a pixel stream with sof/eol/eof markers.
// Optional row checksum output enabled by defining ROW_UNPACKER_CKSUM_EN.
module row_unpacker #(
  parameter int COL   = 1920,
  parameter int ROW   = 1080,
  parameter int WIDTH = 8,
  parameter int CH    = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [COL*WIDTH*CH-1:0] row_in,
  input  logic                  row_valid,
  output logic                  row_ready,
  output logic [WIDTH*CH-1:0]   pix_data,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic                  pix_sof,
  output logic                  pix_eol,
  output logic                  pix_eof,
  output logic                  busy
`ifdef ROW_UNPACKER_CKSUM_EN
  ,
  output logic [15:0]           row_cksum,
  output logic                  row_cksum_valid
`endif
);

  localparam int PW = WIDTH * CH;
  localparam int CW = (COL > 1) ? $clog2(COL) : 1;
  localparam int RW = (ROW > 1) ? $clog2(ROW) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(COL - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROW - 1);

  localparam logic [0:0] EMPTY  = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;

  logic [0:0]    state;
  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;
  logic [PW-1:0] row_buf [COL];

  logic streaming;
  logic last_pix;
  logic pix_fire;
  logic capture;

  assign streaming = (state == STREAM);
  assign last_pix  = (col_cnt == COL_LAST);
  assign pix_fire  = streaming && pix_ready;
  assign row_ready = !streaming || (pix_ready && last_pix);
  assign capture   = row_valid && row_ready;

  assign pix_valid = streaming;
  assign pix_data  = row_buf[col_cnt];
  assign pix_sof   = streaming && (row_cnt == '0) && (col_cnt == '0);
  assign pix_eol   = streaming && last_pix;
  assign pix_eof   = pix_eol && (row_cnt == ROW_LAST);
  assign busy      = streaming;

  // A capture on the eol transfer keeps STREAM so rows follow with no bubble.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= EMPTY;
      col_cnt <= '0;
      row_cnt <= '0;
      for (int k = 0; k < COL; k++) begin
        row_buf[k] <= '0;
      end
    end else begin
      if (pix_fire) begin
        if (last_pix) begin
          col_cnt <= '0;
          row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + 1'b1;
        end else begin
          col_cnt <= col_cnt + 1'b1;
        end
      end
      if (capture) begin
        state   <= STREAM;
        col_cnt <= '0;
        for (int k = 0; k < COL; k++) begin
          row_buf[k] <= row_in[(COL-1-k)*PW +: PW];
        end
      end else if (pix_fire && last_pix) begin
        state <= EMPTY;
      end
    end
  end

`ifdef ROW_UNPACKER_CKSUM_EN
  logic [15:0] ch_sum;
  logic [15:0] acc;

  always_comb begin
    ch_sum = '0;
    for (int c = 0; c < CH; c++) begin
      ch_sum = ch_sum + 16'(pix_data[PW-1-c*WIDTH -: WIDTH]);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      acc             <= '0;
      row_cksum       <= '0;
      row_cksum_valid <= 1'b0;
    end else begin
      row_cksum_valid <= 1'b0;
      if (pix_fire) begin
        if (last_pix) begin
          row_cksum       <= acc + ch_sum;
          acc             <= '0;
          row_cksum_valid <= 1'b1;
        end else begin
          acc <= acc + ch_sum;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_row_unpacker.sv
// Directed bench for row_unpacker with COL=4, ROW=2, 8-bit x 3 channels.
// Checksum scenario runs only when ROW_UNPACKER_CKSUM_EN is defined.
module tb_row_unpacker;

  localparam int COL = 4;
  localparam int ROW = 2;
  localparam int WIDTH = 8;
  localparam int CH = 3;
  localparam int PW = WIDTH * CH;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic [COL*PW-1:0] row_in = '0;
  logic row_valid = 1'b0;
  logic row_ready;
  logic [PW-1:0] pix_data;
  logic pix_valid;
  logic pix_ready = 1'b1;
  logic pix_sof;
  logic pix_eol;
  logic pix_eof;
  logic busy;
`ifdef ROW_UNPACKER_CKSUM_EN
  logic [15:0] row_cksum;
  logic row_cksum_valid;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [COL*PW-1:0] R1 = 96'h010203_040506_070809_0A0B0C;
  localparam logic [COL*PW-1:0] R2 = 96'hAAAAAA_BBBBBB_CCCCCC_DDDDDD;

  logic [PW-1:0] exp1 [COL] = '{24'h010203, 24'h040506, 24'h070809, 24'h0A0B0C};
  logic [PW-1:0] exp2 [COL] = '{24'hAAAAAA, 24'hBBBBBB, 24'hCCCCCC, 24'hDDDDDD};

  row_unpacker #(.COL(COL), .ROW(ROW), .WIDTH(WIDTH), .CH(CH)) dut (
    .CLK(CLK),
    .RST(RST),
    .row_in(row_in),
    .row_valid(row_valid),
    .row_ready(row_ready),
    .pix_data(pix_data),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .pix_sof(pix_sof),
    .pix_eol(pix_eol),
    .pix_eof(pix_eof),
    .busy(busy)
`ifdef ROW_UNPACKER_CKSUM_EN
    ,
    .row_cksum(row_cksum),
    .row_cksum_valid(row_cksum_valid)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    RST = 1'b1;
    row_valid = 1'b0;
    pix_ready = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset;
    RST = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 1) RST = 1'b0;
      n_cmp++;
      if ({pix_valid, row_ready, busy, pix_sof, pix_eol, pix_eof} !== 6'b010000) begin
        n_bad++;
        $display("FAIL reset_idle[%0d]: got v/rdy/busy/sof/eol/eof=%b need 010000", i,
          {pix_valid, row_ready, busy, pix_sof, pix_eol, pix_eof});
      end
    end
  endtask

  task automatic test_single_row;
    do_reset();
    row_in = R1;
    row_valid = 1'b1;
    tick();
    row_valid = 1'b0;
    for (int k = 0; k < COL; k++) begin
      n_cmp++;
      if (pix_valid !== 1'b1 || pix_data !== exp1[k] || pix_sof !== (k == 0)
          || pix_eol !== (k == COL-1) || pix_eof !== 1'b0 || busy !== 1'b1) begin
        n_bad++;
        $display("FAIL single_pix[%0d]: got v=%b d=%h sof=%b eol=%b eof=%b busy=%b need d=%h",
          k, pix_valid, pix_data, pix_sof, pix_eol, pix_eof, busy, exp1[k]);
      end
      tick();
    end
    n_cmp++;
    if (pix_valid !== 1'b0 || busy !== 1'b0 || row_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL single_empty: got v=%b busy=%b rdy=%b need 0 0 1",
        pix_valid, busy, row_ready);
    end
  endtask

  task automatic test_backpressure;
    int xfers;
    int k;
    do_reset();
    row_in = R1;
    row_valid = 1'b1;
    tick();
    row_valid = 1'b0;
    xfers = 0;
    k = 0;
    for (int c = 0; c < 12 && k < COL; c++) begin
      pix_ready = !(c >= 1 && c <= 3);
      n_cmp++;
      if (pix_valid !== 1'b1 || pix_data !== exp1[k]) begin
        n_bad++;
        $display("FAIL bp_pix[c%0d]: got v=%b d=%h need v=1 d=%h", c, pix_valid, pix_data, exp1[k]);
      end
      if (!pix_ready) begin
        n_cmp++;
        if (row_ready !== 1'b0) begin
          n_bad++;
          $display("FAIL bp_rdy[c%0d]: got row_ready=%b need 0", c, row_ready);
        end
      end
      if (pix_valid && pix_ready) begin
        xfers++;
        k++;
      end
      tick();
    end
    pix_ready = 1'b1;
    n_cmp++;
    if (xfers != COL || pix_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_total: got xfers=%0d v=%b need %0d and v=0", xfers, pix_valid, COL);
    end
  endtask

  task automatic test_back_to_back;
    logic [PW-1:0] e;
    do_reset();
    row_in = R1;
    row_valid = 1'b1;
    n_cmp++;
    if (row_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_empty_rdy: got %b need 1", row_ready);
    end
    tick();
    for (int k = 0; k < 2*COL; k++) begin
      e = (k < COL) ? exp1[k] : exp2[k-COL];
      n_cmp++;
      if (pix_valid !== 1'b1 || pix_data !== e || pix_sof !== (k == 0)
          || pix_eol !== (k % COL == COL-1) || pix_eof !== (k == 2*COL-1)
          || row_ready !== (k % COL == COL-1)) begin
        n_bad++;
        $display("FAIL b2b_pix[%0d]: got v=%b d=%h sof=%b eol=%b eof=%b rdy=%b need d=%h",
          k, pix_valid, pix_data, pix_sof, pix_eol, pix_eof, row_ready, e);
      end
      if (k == COL-1) row_in = R2;
      if (k == 2*COL-1) row_in = R1;
      tick();
    end
    row_valid = 1'b0;
    n_cmp++;
    if (pix_valid !== 1'b1 || pix_sof !== 1'b1 || pix_data !== exp1[0]) begin
      n_bad++;
      $display("FAIL b2b_wrap_sof: got v=%b sof=%b d=%h need 1 1 %h",
        pix_valid, pix_sof, pix_data, exp1[0]);
    end
  endtask

  task automatic test_reset_mid_row;
    do_reset();
    row_in = R1;
    row_valid = 1'b1;
    tick();
    row_valid = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (pix_data !== exp1[2]) begin
      n_bad++;
      $display("FAIL mid_pre: got d=%h need %h", pix_data, exp1[2]);
    end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    n_cmp++;
    if (pix_valid !== 1'b0 || busy !== 1'b0 || row_ready !== 1'b1 || pix_eol !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset: got v=%b busy=%b rdy=%b eol=%b need 0 0 1 0",
        pix_valid, busy, row_ready, pix_eol);
    end
    row_in = R2;
    row_valid = 1'b1;
    tick();
    row_valid = 1'b0;
    n_cmp++;
    if (pix_valid !== 1'b1 || pix_sof !== 1'b1 || pix_data !== exp2[0]) begin
      n_bad++;
      $display("FAIL mid_restart: got v=%b sof=%b d=%h need 1 1 %h",
        pix_valid, pix_sof, pix_data, exp2[0]);
    end
  endtask

`ifdef ROW_UNPACKER_CKSUM_EN
  task automatic test_cksum;
    do_reset();
    row_in = R1;
    row_valid = 1'b1;
    tick();
    row_valid = 1'b0;
    for (int k = 0; k < COL; k++) begin
      n_cmp++;
      if (row_cksum_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL cksum_early[%0d]: got valid=%b need 0", k, row_cksum_valid);
      end
      tick();
    end
    n_cmp++;
    if (row_cksum_valid !== 1'b1 || row_cksum !== 16'h004E) begin
      n_bad++;
      $display("FAIL cksum_done: got valid=%b sum=%h need 1 004e", row_cksum_valid, row_cksum);
    end
    tick();
    n_cmp++;
    if (row_cksum_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL cksum_pulse: got valid=%b need 0", row_cksum_valid);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_row();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_row();
`ifdef ROW_UNPACKER_CKSUM_EN
    test_cksum();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/row_unpacker.md
Name: row_unpacker

Overview:
- Reader-side counterpart of the filter's row bus. It accepts one filtered output row as a single wide parallel word, COL pixels x 24 bits.
- It streams that row out as one pixel per clock under a valid/ready handshake, with start-of-frame, end-of-line and end-of-frame markers.
- It sits between the NSCLR row output and the pixel sink (file writer, DMA or display path). This replaces the bench-side slicing loop with synthesizable RTL.

Parameters:
- COL, 1920, pixels per row
- ROW, 1080, rows per frame
- WIDTH, 8, bits per colour channel
- CH, 3, channels per pixel; pixel width PW = WIDTH*CH (24)

Ports:
- CLK  input  1  single clock, all logic on the rising edge
- RST  input  1  synchronous, active-high reset
- row_in  input  COL*PW  one filtered row; pixel 0 is bits [COL*PW-1 -: PW], pixel COL-1 is bits [PW-1:0]
- row_valid  input  1  row_in is valid
- row_ready  output  1  block can capture row_in this cycle
- pix_data  output  PW  current pixel; channel 0 is bits [PW-1 -: WIDTH]
- pix_valid  output  1  pix_data is valid
- pix_ready  input  1  sink accepts pix_data
- pix_sof  output  1  qualifies pixel 0 of row 0
- pix_eol  output  1  qualifies the last pixel of each row
- pix_eof  output  1  qualifies the last pixel of row ROW-1
- busy  output  1  a row is held or being streamed

Behaviour:
Reset (RST=1 at a clock edge):
- State goes to EMPTY. Row buffer, col_cnt and row_cnt clear to 0.
- pix_valid=0, pix_sof=0, pix_eol=0, pix_eof=0, busy=0. row_ready=1 from the first cycle after reset.
- Reset wins over every simultaneous event. A row in flight is discarded, with no partial completion.

Row capture:
- A row is captured when row_valid and row_ready are both 1 at an edge. row_in is copied into the row buffer and col_cnt is set to 0.

Pixel handshake:
- A pixel transfers when pix_valid and pix_ready are both 1 at an edge.
- pix_data is selected from the buffer by col_cnt, where pixel k = buf[(COL-1-k)*PW +: PW]. It is registered or combinational from registered state; there is no combinational path from row_in.

States:
- EMPTY:
  - row_ready=1, pix_valid=0.
  - On capture, go to STREAM. pix_valid=1 on the next cycle, so latency from row capture to the first pixel valid is 1 cycle.
- STREAM:
  - pix_valid=1. It stays high and pix_data stays stable while pix_ready=0.
  - On each transfer, col_cnt increments.
  - On the transfer of pixel COL-1: col_cnt goes to 0 and row_cnt increments, wrapping from ROW-1 to 0.
  - If row_valid is also 1 in that same cycle, the next row is captured and the state stays STREAM, giving back-to-back streaming with no bubble. Otherwise the state goes to EMPTY.
  - row_ready = (state==EMPTY) or (state==STREAM and pix_ready and col_cnt==COL-1).

Markers (each qualified by pix_valid):
- pix_sof = (row_cnt==0 and col_cnt==0).
- pix_eol = (col_cnt==COL-1).
- pix_eof = pix_eol and (row_cnt==ROW-1).

busy:
- busy = (state==STREAM).

Boundaries:
- row_valid in STREAM before the last pixel: it is ignored, because row_ready=0. The upstream must hold row_valid.
- COL=1: every pixel is both sof-candidate and eol.
- Counter widths are clog2(COL) and clog2(ROW), minimum 1.
- row_cnt never exceeds ROW-1.

Optional Feature:
Macro ROW_UNPACKER_CKSUM_EN.
- When defined:
  - Adds output row_cksum [15:0] and output row_cksum_valid [0:0].
  - The checksum is the modulo-2^16 sum of every WIDTH-bit channel of every pixel transferred in the current row.
  - It is accumulated on each pixel transfer and cleared to 0 after the eol transfer and on reset.
  - row_cksum_valid pulses 1 cycle after the eol transfer, with row_cksum holding the completed sum.
- When undefined: these ports and the accumulator do not exist, and all other behaviour is identical.

Test Plan:
Benches use COL=4, ROW=2, WIDTH=8, CH=3.
1. Reset then idle:
   - Stimulus: hold RST=1 for 2 cycles, then release.
   - Required: pix_valid=0, row_ready=1 and busy=0 throughout, with no markers.
2. Single row, pix_ready=1:
   - Stimulus: row_in=96'h010203_040506_070809_0A0B0C, row_valid pulsed for one cycle.
   - Required: pix_data is 010203, 040506, 070809, 0A0B0C on 4 consecutive cycles starting 1 cycle after capture. sof on the first pixel, eol on the fourth, no eof. State then returns to EMPTY.
3. Backpressure:
   - Stimulus: as scenario 2, but drop pix_ready for 3 cycles on pixel 1.
   - Required: pix_data holds 040506 with pix_valid=1 for those cycles. No pixel is lost or duplicated, and the total is 4 transfers.
4. Back-to-back rows:
   - Stimulus: row_valid held high with a second row 96'hAAAAAA_BBBBBB_CCCCCC_DDDDDD.
   - Required: row_ready=1 only in the EMPTY cycle and the eol-transfer cycle. 8 transfers with no bubble. eof on DDDDDD, then row_cnt returns to 0, so the next row's first pixel has sof=1.
5. Reset mid-row:
   - Stimulus: assert RST after 2 pixel transfers.
   - Required: pix_valid=0 the next cycle. After a new capture, the first pixel is pixel 0 with sof=1.
6. With ROW_UNPACKER_CKSUM_EN, scenario 2 data:
   - Required: row_cksum=16'h004E (sum of 1..12 = 78) and row_cksum_valid high for 1 cycle after the eol transfer.
